// File: rtl/reg_port_sequencer_if.sv
// Register-port sequencer bundle: decoder request, execute-stage handshake
// and the register-file A/B read ports and D write port.
// The master modport is the sequencer side; the slave modport is everything around it.
interface reg_port_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_rs_a;
    logic [ADDR_W-1:0] req_rs_b;
    logic [ADDR_W-1:0] req_rd;
    logic              op_valid;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;
    logic              wb_done;
    logic [ADDR_W-1:0] regAddrA;
    logic [ADDR_W-1:0] regAddrB;
    logic [ADDR_W-1:0] regAddrD;
    logic              regReA;
    logic              regReB;
    logic              regWeD;
    logic [DATA_W-1:0] busA;
    logic [DATA_W-1:0] busB;
    logic [DATA_W-1:0] busD;

    modport master (
        input  req_valid, req_rs_a, req_rs_b, req_rd, res_valid, res_data, busA, busB,
        output req_ready, op_valid, op_a, op_b, res_ready, wb_done,
               regAddrA, regAddrB, regAddrD, regReA, regReB, regWeD, busD
    );

    modport slave (
        output req_valid, req_rs_a, req_rs_b, req_rd, res_valid, res_data, busA, busB,
        input  req_ready, op_valid, op_a, op_b, res_ready, wb_done,
               regAddrA, regAddrB, regAddrD, regReA, regReB, regWeD, busD
    );
endinterface

// File: rtl/reg_port_sequencer.sv
// Register-port sequencer: reads two operands from the register file, hands
// them to the execute stage, then writes the result back with a
// setup / strobe (/ hold) sequence on regWeD. One request in flight at a time.
// All outputs are registered.
// Optional macro REGSEQ_WB_HOLD_EN adds a WB_HOLD cycle after the strobe so
// address and data stay stable across the falling edge of regWeD.
module reg_port_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_port_sequencer_if.master  sif
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        EXEC      = 3'd2,
        WB_SETUP  = 3'd3,
        WB_STROBE = 3'd4,
        WB_HOLD   = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic              req_ready_q, req_ready_d;
    logic              op_valid_q, op_valid_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic              res_ready_q, res_ready_d;
    logic              wb_done_q, wb_done_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic [ADDR_W-1:0] addr_d_q, addr_d_d;
    logic              re_a_q, re_a_d;
    logic              re_b_q, re_b_d;
    logic              we_d_q, we_d_d;
    logic [DATA_W-1:0] bus_d_q, bus_d_d;

    // Next-state and next-output logic; every register holds unless its state changes it.
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        req_ready_d = req_ready_q;
        op_valid_d  = op_valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_ready_d = res_ready_q;
        wb_done_d   = wb_done_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        addr_d_d    = addr_d_q;
        re_a_d      = re_a_q;
        re_b_d      = re_b_q;
        we_d_d      = 1'b0;
        bus_d_d     = bus_d_q;

        case (state_q)
            IDLE: begin
                if (sif.req_valid && req_ready_q) begin
                    state_d     = READ;
                    req_ready_d = 1'b0;
                    rd_d        = sif.req_rd;
                    addr_a_d    = sif.req_rs_a;
                    addr_b_d    = sif.req_rs_b;
                    // r0 is never read from the bus, so its port stays disabled.
                    re_a_d      = (sif.req_rs_a != '0);
                    re_b_d      = (sif.req_rs_b != '0);
                end
            end
            READ: begin
                state_d     = EXEC;
                op_a_d      = re_a_q ? sif.busA : '0;
                op_b_d      = re_b_q ? sif.busB : '0;
                re_a_d      = 1'b0;
                re_b_d      = 1'b0;
                op_valid_d  = 1'b1;
                res_ready_d = 1'b1;
            end
            EXEC: begin
                if (sif.res_valid) begin
                    state_d     = WB_SETUP;
                    op_valid_d  = 1'b0;
                    res_ready_d = 1'b0;
                    addr_d_d    = rd_q;
                    bus_d_d     = sif.res_data;
                end
            end
            WB_SETUP: begin
                if (rd_q == '0) begin
                    state_d   = DONE;
                    wb_done_d = 1'b1;
                end else begin
                    state_d = WB_STROBE;
                    we_d_d  = 1'b1;
                end
            end
            WB_STROBE: begin
`ifdef REGSEQ_WB_HOLD_EN
                state_d   = WB_HOLD;
`else
                state_d   = DONE;
                wb_done_d = 1'b1;
`endif
            end
            WB_HOLD: begin
                state_d   = DONE;
                wb_done_d = 1'b1;
            end
            DONE: begin
                state_d     = IDLE;
                wb_done_d   = 1'b0;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                op_valid_d  = 1'b0;
                res_ready_d = 1'b0;
                wb_done_d   = 1'b0;
                re_a_d      = 1'b0;
                re_b_d      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any sequence and drops regWeD at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_q        <= '0;
            req_ready_q <= 1'b1;
            op_valid_q  <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_ready_q <= 1'b0;
            wb_done_q   <= 1'b0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            addr_d_q    <= '0;
            re_a_q      <= 1'b0;
            re_b_q      <= 1'b0;
            we_d_q      <= 1'b0;
            bus_d_q     <= '0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            req_ready_q <= req_ready_d;
            op_valid_q  <= op_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_ready_q <= res_ready_d;
            wb_done_q   <= wb_done_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            addr_d_q    <= addr_d_d;
            re_a_q      <= re_a_d;
            re_b_q      <= re_b_d;
            we_d_q      <= we_d_d;
            bus_d_q     <= bus_d_d;
        end
    end

    assign sif.req_ready = req_ready_q;
    assign sif.op_valid  = op_valid_q;
    assign sif.op_a      = op_a_q;
    assign sif.op_b      = op_b_q;
    assign sif.res_ready = res_ready_q;
    assign sif.wb_done   = wb_done_q;
    assign sif.regAddrA  = addr_a_q;
    assign sif.regAddrB  = addr_b_q;
    assign sif.regAddrD  = addr_d_q;
    assign sif.regReA    = re_a_q;
    assign sif.regReB    = re_b_q;
    assign sif.regWeD    = we_d_q;
    assign sif.busD      = bus_d_q;
endmodule

// File: tb/tb_reg_port_sequencer.sv
// Testbench for reg_port_sequencer: a behavioural 32 x 16 register file
// around the DUT, a table of directed requests, and hand-written sequences
// for reset and a reset that lands in the middle of a write strobe.
module tb_reg_port_sequencer;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;

`ifdef REGSEQ_WB_HOLD_EN
    localparam int WB_CYC = 4;
`else
    localparam int WB_CYC = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;

    reg_port_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) sif ();

    reg_port_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    always #5 clk = ~clk;

    // Register file model. Entry 0 holds junk so that reading r0 off the bus
    // would be visible. The file shares the reset, and a strobe that coincides
    // with reset is discarded.
    logic [DATA_W-1:0] rf [32];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
            rf[0] <= 16'hDEAD;
            rf[3] <= 16'h1234;
            rf[4] <= 16'h00FF;
            rf[7] <= 16'h7777;
            rf[9] <= 16'hA5A5;
        end else if (sif.regWeD && !rst && sif.regAddrD != '0) begin
            rf[sif.regAddrD] <= sif.busD;
        end
    end
    assign sif.busA = rf[sif.regAddrA];
    assign sif.busB = rf[sif.regAddrB];

    typedef struct {
        logic [ADDR_W-1:0] rs_a;
        logic [ADDR_W-1:0] rs_b;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] res;
        int                delay;
        logic [DATA_W-1:0] exp_a;
        logic [DATA_W-1:0] exp_b;
    } vec_t;

    vec_t vecs [8];
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (sif.req_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready_wait", {31'd0, sif.req_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int  n;
        int  we_cnt;
        bit  seen;
        wait_ready();
        sif.req_valid = 1'b1;
        sif.req_rs_a  = v.rs_a;
        sif.req_rs_b  = v.rs_b;
        sif.req_rd    = v.rd;
        @(negedge clk);  // READ
        sif.req_valid = 1'b0;
        chk("read_addrA", sif.regAddrA, v.rs_a);
        chk("read_addrB", sif.regAddrB, v.rs_b);
        chk("read_reA", sif.regReA, v.rs_a != 0);
        chk("read_reB", sif.regReB, v.rs_b != 0);
        chk("read_req_ready", sif.req_ready, 0);
        // A result offered before EXEC must be ignored.
        sif.res_valid = 1'b1;
        sif.res_data  = 16'hFFFF;
        @(negedge clk);  // first EXEC cycle
        sif.res_valid = 1'b0;
        chk("exec_op_valid", sif.op_valid, 1);
        chk("exec_res_ready", sif.res_ready, 1);
        chk("exec_op_a", sif.op_a, v.exp_a);
        chk("exec_op_b", sif.op_b, v.exp_b);
        chk("exec_reA", sif.regReA, 0);
        for (int i = 0; i < v.delay; i++) begin
            sif.req_valid = 1'b1;
            sif.req_rd    = 5'd1;
            @(negedge clk);
            chk("wait_op_valid", sif.op_valid, 1);
            chk("wait_op_a", sif.op_a, v.exp_a);
            chk("wait_op_b", sif.op_b, v.exp_b);
            chk("wait_req_ready", sif.req_ready, 0);
        end
        sif.req_valid = 1'b0;
        sif.res_valid = 1'b1;
        sif.res_data  = v.res;
        n = 0;
        we_cnt = 0;
        seen = 0;
        while (!seen && n < 12) begin
            @(negedge clk);
            n++;
            sif.res_valid = 1'b0;
            if (sif.regWeD) we_cnt++;
            chk("wb_we_cycle", sif.regWeD, (v.rd != 0) && (n == 2));
            chk("wb_addrD", sif.regAddrD, v.rd);
            chk("wb_busD", sif.busD, v.res);
            chk("wb_op_valid", sif.op_valid, 0);
            if (sif.wb_done) seen = 1;
        end
        chk("wb_done_latency", n, (v.rd != 0) ? WB_CYC : 2);
        chk("wb_we_count", we_cnt, (v.rd != 0) ? 1 : 0);
        @(negedge clk);
        chk("post_req_ready", sif.req_ready, 1);
        chk("post_wb_done", sif.wb_done, 0);
        chk("post_we", sif.regWeD, 0);
        if (v.rd != 0) chk("rf_written", rf[v.rd], v.res);
    endtask

    initial begin
        vecs[0] = '{rs_a: 5'd3,  rs_b: 5'd4, rd: 5'd5,  res: 16'h1333, delay: 0, exp_a: 16'h1234, exp_b: 16'h00FF};
        vecs[1] = '{rs_a: 5'd0,  rs_b: 5'd0, rd: 5'd0,  res: 16'hBEEF, delay: 0, exp_a: 16'h0000, exp_b: 16'h0000};
        vecs[2] = '{rs_a: 5'd9,  rs_b: 5'd9, rd: 5'd6,  res: 16'h5A5A, delay: 3, exp_a: 16'hA5A5, exp_b: 16'hA5A5};
        vecs[3] = '{rs_a: 5'd5,  rs_b: 5'd0, rd: 5'd10, res: 16'h0001, delay: 1, exp_a: 16'h1333, exp_b: 16'h0000};
        vecs[4] = '{rs_a: 5'd10, rs_b: 5'd6, rd: 5'd0,  res: 16'h7777, delay: 2, exp_a: 16'h0001, exp_b: 16'h5A5A};
        vecs[5] = '{rs_a: 5'd0,  rs_b: 5'd9, rd: 5'd14, res: 16'h000E, delay: 0, exp_a: 16'h0000, exp_b: 16'hA5A5};
        vecs[6] = '{rs_a: 5'd14, rs_b: 5'd7, rd: 5'd31, res: 16'hFFFF, delay: 0, exp_a: 16'h000E, exp_b: 16'h7777};
        vecs[7] = '{rs_a: 5'd31, rs_b: 5'd5, rd: 5'd1,  res: 16'h0000, delay: 1, exp_a: 16'hFFFF, exp_b: 16'h1333};

        sif.req_valid = 1'b0;
        sif.req_rs_a  = '0;
        sif.req_rs_b  = '0;
        sif.req_rd    = '0;
        sif.res_valid = 1'b0;
        sif.res_data  = '0;

        repeat (3) @(negedge clk);
        preload = 1'b0;
        rst     = 1'b0;
        chk("rst_req_ready", sif.req_ready, 1);
        chk("rst_op_valid", sif.op_valid, 0);
        chk("rst_res_ready", sif.res_ready, 0);
        chk("rst_wb_done", sif.wb_done, 0);
        chk("rst_we", sif.regWeD, 0);
        chk("rst_reA", sif.regReA, 0);
        chk("rst_busD", sif.busD, 0);
        chk("rst_op_a", sif.op_a, 0);

        // Reset landing while regWeD is high: the write to r7 must not happen.
        wait_ready();
        sif.req_valid = 1'b1;
        sif.req_rs_a  = 5'd0;
        sif.req_rs_b  = 5'd0;
        sif.req_rd    = 5'd7;
        @(negedge clk);  // READ
        sif.req_valid = 1'b0;
        @(negedge clk);  // EXEC
        sif.res_valid = 1'b1;
        sif.res_data  = 16'h4242;
        @(negedge clk);  // WB_SETUP
        sif.res_valid = 1'b0;
        chk("abort_setup_we", sif.regWeD, 0);
        @(negedge clk);  // WB_STROBE
        chk("abort_strobe_we", sif.regWeD, 1);
        chk("abort_strobe_addr", sif.regAddrD, 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_we", sif.regWeD, 0);
        chk("abort_req_ready", sif.req_ready, 1);
        chk("abort_op_valid", sif.op_valid, 0);
        chk("abort_wb_done", sif.wb_done, 0);
        chk("abort_r7", rf[7], 16'h7777);
        // No retry of the aborted write afterwards.
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_retry", sif.regWeD, 0);
        end

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
